calc_exec_ctrl: RTL



---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_bin2bcd.sv | 74 +++++++
 rtl/calc_exec_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared constants, state encoding and BCD helpers for the
//                calculator execution controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BIN_W       = 7;
    localparam int RES_W       = 14;

    localparam logic [3:0] OP_ADD = 4'ha;
    localparam logic [3:0] OP_SUB = 4'hb;
    localparam logic [3:0] OP_MUL = 4'hc;
    localparam logic [3:0] OP_DIV = 4'hd;

    localparam logic [2:0] ITER_LAST = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_CONV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic bcd_byte_ok(input logic [7:0] bcd);
        return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    endfunction

    // tens*10 + ones; only meaningful for valid BCD
    function automatic logic [BIN_W-1:0] bcd_byte_to_bin(input logic [7:0] bcd);
        logic [7:0] w_t;
        w_t = ({4'd0, bcd[7:4]} << 3) + ({4'd0, bcd[7:4]} << 1) + {4'd0, bcd[3:0]};
        return w_t[BIN_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : calc_bin2bcd
//  Description : Sequential double-dabble converter, one input bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WIDTH-1:0]                bin,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SH_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_first_left = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    logic [SH_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [SH_W-1:0]  w_step_in;
    logic [SH_W-1:0]  w_adj;
    logic [SH_W-1:0]  w_step;

    // The first shift happens on the start edge; BCD digits are zero then,
    // so no adjust is needed and the result is ready WIDTH edges later.
    assign w_step_in = start ? {{BCD_W{1'b0}}, bin} : r_shift;
    assign w_adj[WIDTH-1:0] = w_step_in[WIDTH-1:0];

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            localparam int LSB = WIDTH + BCD_DIGIT_W * d;
            assign w_adj[LSB +: BCD_DIGIT_W] =
                (w_step_in[LSB +: BCD_DIGIT_W] >= 4'd5) ?
                4'(w_step_in[LSB +: BCD_DIGIT_W] + 4'd3) :
                w_step_in[LSB +: BCD_DIGIT_W];
        end
    endgenerate

    assign w_step = {w_adj[SH_W-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_shift <= w_step;
            r_cnt   <= c_first_left;
            r_done  <= 1'b0;
        end else if (r_cnt != '0) begin
            r_shift <= w_step;
            r_cnt   <= r_cnt - c_one;
            if (r_cnt == c_one) begin
                r_done <= 1'b1;
            end
        end
    end

    // done is sticky until the next start so the shorter instance waits
    assign done = r_done;
    assign bcd  = r_shift[SH_W-1 -: BCD_W];

endmodule
`default_nettype wire

// File: rtl/calc_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : calc_exec_ctrl
//  Description : Sequenced add/sub/mul/div engine on 2-digit BCD operands
//                with a 4-digit BCD result and done/err/neg flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_exec_ctrl
    import calc_pkg::*;
#(
    parameter bit SIGNED_SUB = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [7:0]  a_bcd,
    input  logic [7:0]  b_bcd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        neg,
    output logic [15:0] res_bcd,
    output logic [7:0]  rem_bcd
);

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_a_bcd;
    logic [7:0]         r_b_bcd;
    logic [3:0]         r_op;
    logic [2:0]         r_cnt;
    logic [RES_W-1:0]   r_acc;
    logic               r_neg_pend;

    logic [BIN_W-1:0]   w_a_bin;
    logic [BIN_W-1:0]   w_b_bin;
    logic               w_a_lt_b;
    logic               w_load_err;
    logic               w_exec_last;
    logic               w_conv_start;
    logic               w_out_ok;
    logic               w_out_err;
    logic [7:0]         w_trial;
    logic               w_trial_ge;
    logic [BIN_W-1:0]   w_rem_step;
    logic [RES_W-1:0]   w_acc_next;
    logic [RES_W-1:0]   w_res_bin;
    logic [BIN_W-1:0]   w_rem_bin;
    logic [15:0]        w_res_conv;
    logic [7:0]         w_rem_conv;
    logic               w_res_done;
    logic               w_rem_done;

    assign w_a_bin  = bcd_byte_to_bin(r_a_bcd);
    assign w_b_bin  = bcd_byte_to_bin(r_b_bcd);
    assign w_a_lt_b = (w_a_bin < w_b_bin);

    always_comb begin
        w_load_err = 1'b0;
        if (!bcd_byte_ok(r_a_bcd) || !bcd_byte_ok(r_b_bcd)) begin
            w_load_err = 1'b1;
        end else begin
            case (r_op)
                OP_ADD, OP_MUL: w_load_err = 1'b0;
                OP_SUB:         w_load_err = w_a_lt_b && !SIGNED_SUB;
                OP_DIV:         w_load_err = (w_b_bin == '0);
                default:        w_load_err = 1'b1;
            endcase
        end
    end

    // Restoring division keeps {partial remainder, quotient} in r_acc
    assign w_trial    = {r_acc[RES_W-1:BIN_W], r_acc[BIN_W-1]};
    assign w_trial_ge = (w_trial >= {1'b0, w_b_bin});
    assign w_rem_step = w_trial_ge ? 7'(w_trial - {1'b0, w_b_bin}) : w_trial[BIN_W-1:0];

    always_comb begin
        w_acc_next = r_acc;
        case (r_op)
            OP_ADD: w_acc_next = RES_W'(w_a_bin) + RES_W'(w_b_bin);
            OP_SUB: w_acc_next = w_a_lt_b ? (RES_W'(w_b_bin) - RES_W'(w_a_bin))
                                          : (RES_W'(w_a_bin) - RES_W'(w_b_bin));
            OP_MUL: w_acc_next = w_b_bin[r_cnt] ? (r_acc + (RES_W'(w_a_bin) << r_cnt)) : r_acc;
            OP_DIV: w_acc_next = {w_rem_step, r_acc[BIN_W-2:0], w_trial_ge};
            default: w_acc_next = r_acc;
        endcase
    end

    assign w_res_bin = (r_op == OP_DIV) ? {{(RES_W-BIN_W){1'b0}}, w_acc_next[BIN_W-1:0]} : w_acc_next;
    assign w_rem_bin = (r_op == OP_DIV) ? w_acc_next[RES_W-1:BIN_W] : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the error path holds LOAD one extra cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_LOAD;
            S_LOAD: begin
                if (!w_load_err)        w_state_next = S_EXEC;
                else if (r_cnt == 3'd1) w_state_next = S_DONE;
            end
            S_EXEC: if (w_exec_last) w_state_next = S_CONV;
            S_CONV: if (w_res_done && w_rem_done) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        w_exec_last  = 1'b1;
        w_conv_start = 1'b0;
        w_out_ok     = 1'b0;
        w_out_err    = 1'b0;
        if ((r_op == OP_MUL) || (r_op == OP_DIV)) begin
            w_exec_last = (r_cnt == ITER_LAST);
        end
        case (r_state)
            S_LOAD: w_out_err    = w_load_err && (r_cnt == 3'd1);
            S_EXEC: w_conv_start = w_exec_last;
            S_CONV: w_out_ok     = w_res_done && w_rem_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_bcd    <= '0;
            r_b_bcd    <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_neg_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_bcd <= a_bcd;
                        r_b_bcd <= b_bcd;
                        r_op    <= op;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    r_cnt      <= w_load_err ? (r_cnt + 3'd1) : 3'd0;
                    r_acc      <= (r_op == OP_DIV) ? RES_W'(w_a_bin) : '0;
                    r_neg_pend <= (r_op == OP_SUB) && w_a_lt_b;
                end
                S_EXEC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            neg     <= 1'b0;
            res_bcd <= '0;
            rem_bcd <= '0;
        end else begin
            busy <= (w_state_next != S_IDLE);
            done <= (w_state_next == S_DONE);
            if (w_out_err) begin
                err     <= 1'b1;
                neg     <= 1'b0;
                res_bcd <= '0;
                rem_bcd <= '0;
            end else if (w_out_ok) begin
                err     <= 1'b0;
                neg     <= r_neg_pend;
                res_bcd <= w_res_conv;
                rem_bcd <= w_rem_conv;
            end
        end
    end

    calc_bin2bcd #(
        .WIDTH  (RES_W),
        .DIGITS (4)
    ) u_res_conv (
        .clk   (clk),
        .rst   (rst),
        .start (w_conv_start),
        .bin   (w_res_bin),
        .done  (w_res_done),
        .bcd   (w_res_conv)
    );

    calc_bin2bcd #(
        .WIDTH  (BIN_W),
        .DIGITS (2)
    ) u_rem_conv (
        .clk   (clk),
        .rst   (rst),
        .start (w_conv_start),
        .bin   (w_rem_bin),
        .done  (w_rem_done),
        .bcd   (w_rem_conv)
    );

endmodule
`default_nettype wire
